// File: rtl/board_renderer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : board_renderer_pkg
//  Description : Shared constants, types and palette for the board renderer.
//  Revision    : 1.0 - initial release
// ============================================================================
package board_renderer_pkg;

  localparam int COLS  = 10;
  localparam int ROWS  = 20;
  localparam int COL_W = 4;
  localparam int ROW_W = 5;

  typedef logic [2:0]       cell_t;
  typedef logic [11:0]      rgb_t;
  typedef logic [COL_W-1:0] col_t;
  typedef logic [ROW_W-1:0] row_t;

  localparam cell_t CELL_EMPTY = 3'd0;

  localparam rgb_t RGB_BLACK  = 12'h000;
  localparam rgb_t RGB_GAP    = 12'h000;
  localparam rgb_t RGB_EMPTY  = 12'h111;
  localparam rgb_t RGB_BORDER = 12'h888;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

  function automatic rgb_t palette(input cell_t c);
    rgb_t col;
    case (c)
      3'd1:    col = 12'h0FF;
      3'd2:    col = 12'h00F;
      3'd3:    col = 12'hF80;
      3'd4:    col = 12'hFF0;
      3'd5:    col = 12'h0F0;
      3'd6:    col = 12'hF00;
      3'd7:    col = 12'hA0F;
      default: col = RGB_EMPTY;
    endcase
    return col;
  endfunction

endpackage
`default_nettype wire

// File: rtl/board_renderer_if.sv
`default_nettype none
// ============================================================================
//  Module      : board_renderer_if
//  Description : Read port of the board store (renderer is the master).
//  Revision    : 1.0 - initial release
// ============================================================================
interface board_renderer_if;

  logic       cell_rd_en;
  logic [3:0] cell_rd_x;
  logic [4:0] cell_rd_y;
  logic [2:0] cell_rd_data;

  modport master (
    output cell_rd_en,
    output cell_rd_x,
    output cell_rd_y,
    input  cell_rd_data
  );

  modport slave (
    input  cell_rd_en,
    input  cell_rd_x,
    input  cell_rd_y,
    output cell_rd_data
  );

endinterface
`default_nettype wire

// File: rtl/board_renderer_row_fetcher.sv
`default_nettype none
// ============================================================================
//  Module      : board_renderer_row_fetcher
//  Description : Prefetches the next line's board row into a row buffer during hblank.
//  Revision    : 1.0 - initial release
// ============================================================================
module board_renderer_row_fetcher
  import board_renderer_pkg::*;
#(
  parameter int BOARD_Y0 = 80,
  parameter int CELL_PX  = 16,
  parameter int H_ACTIVE = 640,
  parameter int V_TOTAL  = 525
) (
  input  wire logic          clk,
  input  wire logic          reset,
  input  wire logic [9:0]    pixel_x,
  input  wire logic [9:0]    pixel_y,
  board_renderer_if.master   bus,
  input  wire col_t          rd_col,
  output cell_t              rd_cell
);

  localparam int         CELL_SHIFT = $clog2(CELL_PX);
  localparam logic [9:0] C_Y_LO     = 10'(BOARD_Y0);
  localparam logic [9:0] C_Y_HI     = 10'(BOARD_Y0 + ROWS * CELL_PX);
  localparam logic [9:0] C_Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] C_X_TRIG   = 10'(H_ACTIVE);
  localparam col_t       C_LAST_COL = col_t'(COLS - 1);

  fetch_state_t state_q, state_d;
  logic         rd_en_q, rd_en_d;
  col_t         rd_x_q, rd_x_d;
  row_t         rd_y_q, rd_y_d;
  logic         cap_en_q, cap_en_d;
  col_t         cap_col_q, cap_col_d;
  cell_t        rowbuf_q [COLS];
  cell_t        rowbuf_d [COLS];

  logic [9:0]   next_y;
  logic         trigger;

  always_comb begin
    next_y    = (pixel_y == C_Y_LAST) ? 10'd0 : pixel_y + 10'd1;
    trigger   = (pixel_x == C_X_TRIG) && (next_y >= C_Y_LO) && (next_y < C_Y_HI);

    state_d   = state_q;
    rd_en_d   = rd_en_q;
    rd_x_d    = rd_x_q;
    rd_y_d    = rd_y_q;
    rowbuf_d  = rowbuf_q;
    // Board store answers one cycle after each request; capture trails issue by one.
    cap_en_d  = rd_en_q;
    cap_col_d = rd_x_q;
    if (cap_en_q) begin
      rowbuf_d[cap_col_q] = bus.cell_rd_data;
    end

    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          state_d = ST_FETCH;
          rd_en_d = 1'b1;
          rd_x_d  = '0;
          rd_y_d  = row_t'((next_y - C_Y_LO) >> CELL_SHIFT);
        end
      end
      ST_FETCH: begin
        if (rd_x_q == C_LAST_COL) begin
          rd_en_d = 1'b0;
          state_d = ST_DRAIN;
        end else begin
          rd_x_d  = rd_x_q + col_t'(1);
        end
      end
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rd_en_q   <= 1'b0;
      rd_x_q    <= '0;
      rd_y_q    <= '0;
      cap_en_q  <= 1'b0;
      cap_col_q <= '0;
      rowbuf_q  <= '{default: CELL_EMPTY};
    end else begin
      state_q   <= state_d;
      rd_en_q   <= rd_en_d;
      rd_x_q    <= rd_x_d;
      rd_y_q    <= rd_y_d;
      cap_en_q  <= cap_en_d;
      cap_col_q <= cap_col_d;
      rowbuf_q  <= rowbuf_d;
    end
  end

  assign bus.cell_rd_en = rd_en_q;
  assign bus.cell_rd_x  = rd_x_q;
  assign bus.cell_rd_y  = rd_y_q;
  assign rd_cell        = (rd_col < col_t'(COLS)) ? rowbuf_q[rd_col] : CELL_EMPTY;

endmodule
`default_nettype wire

// File: rtl/board_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : board_renderer
//  Description : Renders the playfield to a 12-bit RGB stream; frame counter/tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module board_renderer
  import board_renderer_pkg::*;
#(
  parameter int CELL_PX   = 16,
  parameter int BOARD_X0  = 240,
  parameter int BOARD_Y0  = 80,
  parameter int BORDER_PX = 4,
  parameter int H_ACTIVE  = 640,
  parameter int V_TOTAL   = 525
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic [9:0]  pixel_x,
  input  wire logic [9:0]  pixel_y,
  input  wire logic        video_on,
  input  wire logic        hsync_in,
  input  wire logic        vsync_in,
  board_renderer_if.master bus,
  output rgb_t             rgb,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic [9:0]       framenumber,
  output logic             frame_tick
);

  localparam int         CELL_SHIFT = $clog2(CELL_PX);
  localparam logic [9:0] C_X_LO  = 10'(BOARD_X0);
  localparam logic [9:0] C_X_HI  = 10'(BOARD_X0 + COLS * CELL_PX);
  localparam logic [9:0] C_Y_LO  = 10'(BOARD_Y0);
  localparam logic [9:0] C_Y_HI  = 10'(BOARD_Y0 + ROWS * CELL_PX);
  localparam logic [9:0] C_FX_LO = 10'(BOARD_X0 - BORDER_PX);
  localparam logic [9:0] C_FX_HI = 10'(BOARD_X0 + COLS * CELL_PX + BORDER_PX);
  localparam logic [9:0] C_FY_LO = 10'(BOARD_Y0 - BORDER_PX);
  localparam logic [9:0] C_FY_HI = 10'(BOARD_Y0 + ROWS * CELL_PX + BORDER_PX);

  typedef logic [CELL_SHIFT-1:0] off_t;

  logic  s1_video_q, s1_video_d;
  logic  s1_cell_q, s1_cell_d;
  logic  s1_border_q, s1_border_d;
  col_t  s1_col_q, s1_col_d;
  off_t  s1_offx_q, s1_offx_d;
  off_t  s1_offy_q, s1_offy_d;
  logic  s1_hs_q, s1_hs_d;
  logic  s1_vs_q, s1_vs_d;
  rgb_t  rgb_q, rgb_d;
  logic  hs_q, hs_d;
  logic  vs_q, vs_d;
  logic  vsync_prev_q, vsync_prev_d;
  logic  frame_tick_q, frame_tick_d;
  logic [9:0] framenumber_q, framenumber_d;

  cell_t rd_cell;
  logic  in_cell;
  logic  in_frame;

  board_renderer_row_fetcher #(
    .BOARD_Y0 (BOARD_Y0),
    .CELL_PX  (CELL_PX),
    .H_ACTIVE (H_ACTIVE),
    .V_TOTAL  (V_TOTAL)
  ) u_fetch (
    .clk     (clk),
    .reset   (reset),
    .pixel_x (pixel_x),
    .pixel_y (pixel_y),
    .bus     (bus),
    .rd_col  (s1_col_q),
    .rd_cell (rd_cell)
  );

  always_comb begin
    in_cell  = (pixel_x >= C_X_LO)  && (pixel_x < C_X_HI)  &&
               (pixel_y >= C_Y_LO)  && (pixel_y < C_Y_HI);
    in_frame = (pixel_x >= C_FX_LO) && (pixel_x < C_FX_HI) &&
               (pixel_y >= C_FY_LO) && (pixel_y < C_FY_HI);

    s1_video_d  = video_on;
    s1_cell_d   = in_cell;
    s1_border_d = in_frame && !in_cell;
    s1_col_d    = col_t'((pixel_x - C_X_LO) >> CELL_SHIFT);
    s1_offx_d   = off_t'(pixel_x - C_X_LO);
    s1_offy_d   = off_t'(pixel_y - C_Y_LO);
    s1_hs_d     = hsync_in;
    s1_vs_d     = vsync_in;

    // Occupied cells get a dark right/bottom edge so adjacent blocks stay distinct.
    if (!s1_video_q) begin
      rgb_d = RGB_BLACK;
    end else if (s1_cell_q) begin
      if ((rd_cell != CELL_EMPTY) && ((s1_offx_q == '1) || (s1_offy_q == '1))) begin
        rgb_d = RGB_GAP;
      end else begin
        rgb_d = palette(rd_cell);
      end
    end else if (s1_border_q) begin
      rgb_d = RGB_BORDER;
    end else begin
      rgb_d = RGB_BLACK;
    end
    hs_d = s1_hs_q;
    vs_d = s1_vs_q;

    vsync_prev_d  = vsync_in;
    frame_tick_d  = vsync_in && !vsync_prev_q;
    framenumber_d = framenumber_q + {9'd0, frame_tick_d};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_video_q    <= 1'b0;
      s1_cell_q     <= 1'b0;
      s1_border_q   <= 1'b0;
      s1_col_q      <= '0;
      s1_offx_q     <= '0;
      s1_offy_q     <= '0;
      s1_hs_q       <= 1'b0;
      s1_vs_q       <= 1'b0;
      rgb_q         <= RGB_BLACK;
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      vsync_prev_q  <= 1'b0;
      frame_tick_q  <= 1'b0;
      framenumber_q <= '0;
    end else begin
      s1_video_q    <= s1_video_d;
      s1_cell_q     <= s1_cell_d;
      s1_border_q   <= s1_border_d;
      s1_col_q      <= s1_col_d;
      s1_offx_q     <= s1_offx_d;
      s1_offy_q     <= s1_offy_d;
      s1_hs_q       <= s1_hs_d;
      s1_vs_q       <= s1_vs_d;
      rgb_q         <= rgb_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      vsync_prev_q  <= vsync_prev_d;
      frame_tick_q  <= frame_tick_d;
      framenumber_q <= framenumber_d;
    end
  end

  assign rgb         = rgb_q;
  assign hsync_out   = hs_q;
  assign vsync_out   = vs_q;
  assign framenumber = framenumber_q;
  assign frame_tick  = frame_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_board_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_board_renderer
//  Description : Scoreboard bench for board_renderer with a behavioural board store.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_board_renderer;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  pixel_x, pixel_y;
  logic        video_on, hsync_in, vsync_in;
  logic [11:0] rgb;
  logic        hsync_out, vsync_out;
  logic [9:0]  framenumber;
  logic        frame_tick;

  board_renderer_if bus ();

  board_renderer dut (
    .clk         (clk),
    .reset       (reset),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .video_on    (video_on),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .bus         (bus),
    .rgb         (rgb),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out),
    .framenumber (framenumber),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [2:0]  board [20][10];
  logic [13:0] pq [$];
  logic [8:0]  rq [$];
  logic [9:0]  fq [$];
  logic [9:0]  exp_fn = '0;
  logic        drive_valid = 1'b0;
  logic [1:0]  chk_sr;
  logic        prev_tick = 1'b0;

  // Board store: registered read, one cycle latency.
  always @(posedge clk) begin
    if (bus.cell_rd_en) begin
      if (bus.cell_rd_y < 5'd20 && bus.cell_rd_x < 4'd10)
        bus.cell_rd_data <= board[bus.cell_rd_y][bus.cell_rd_x];
      else
        bus.cell_rd_data <= 3'd0;
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) chk_sr <= 2'b00;
    else       chk_sr <= {chk_sr[0], drive_valid};
  end

  always @(negedge clk) begin
    logic [13:0] e;
    logic [8:0]  r;
    logic [9:0]  f;
    if (chk_sr[1]) begin
      checks++;
      if (pq.size() == 0) begin
        errors++;
        $display("FAIL pix: output with no expectation rgb=%h", rgb);
      end else begin
        e = pq.pop_front();
        if ({rgb, hsync_out, vsync_out} !== e) begin
          errors++;
          $display("FAIL pix: got rgb=%h hs=%b vs=%b want rgb=%h hs=%b vs=%b",
                   rgb, hsync_out, vsync_out, e[13:2], e[1], e[0]);
        end
      end
    end
    if (!reset && bus.cell_rd_en) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL rd: unexpected read x=%0d y=%0d", bus.cell_rd_x, bus.cell_rd_y);
      end else begin
        r = rq.pop_front();
        if ({bus.cell_rd_y, bus.cell_rd_x} !== r) begin
          errors++;
          $display("FAIL rd: got x=%0d y=%0d want x=%0d y=%0d",
                   bus.cell_rd_x, bus.cell_rd_y, r[3:0], r[8:4]);
        end
      end
    end
    if (frame_tick) begin
      checks++;
      if (prev_tick) begin
        errors++;
        $display("FAIL tick: frame_tick high two cycles got=1 want=0");
      end else if (fq.size() == 0) begin
        errors++;
        $display("FAIL tick: unexpected frame_tick framenumber=%0d", framenumber);
      end else begin
        f = fq.pop_front();
        if (framenumber !== f) begin
          errors++;
          $display("FAIL framenumber: got %0d want %0d", framenumber, f);
        end
      end
    end
    prev_tick <= frame_tick;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic von,
                     input logic hs, input logic vs, input logic [11:0] e);
    @(posedge clk); #1;
    if (vs && !vsync_in) begin
      exp_fn = exp_fn + 10'd1;
      fq.push_back(exp_fn);
    end
    pixel_x = x; pixel_y = y; video_on = von; hsync_in = hs; vsync_in = vs;
    drive_valid = 1'b1;
    pq.push_back({e, hs, vs});
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    drive_valid = 1'b0; video_on = 1'b0; pixel_x = 10'd700;
    hsync_in = 1'b0; vsync_in = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic fetch(input logic [9:0] y, input int nreads, input logic [4:0] row);
    @(posedge clk); #1;
    drive_valid = 1'b0; video_on = 1'b0; pixel_x = 10'd640; pixel_y = y;
    for (int c = 0; c < nreads; c++) rq.push_back({row, 4'(c)});
    @(posedge clk); #1;
    pixel_x = 10'd700;
    repeat (12) @(posedge clk);
  endtask

  task automatic vs_pulse();
    @(posedge clk); #1;
    exp_fn = exp_fn + 10'd1;
    fq.push_back(exp_fn);
    vsync_in = 1'b1;
    repeat (2) @(posedge clk);
    #1 vsync_in = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int y = 0; y < 20; y++)
      for (int x = 0; x < 10; x++)
        board[y][x] = 3'd0;
    board[0][0] = 3'd1; board[0][3] = 3'd2; board[0][4] = 3'd3; board[0][5] = 3'd4;
    board[0][6] = 3'd5; board[0][7] = 3'd6; board[0][8] = 3'd7;
    board[7][0] = 3'd5;
    board[5][0] = 3'd6;

    reset = 1'b1;
    pixel_x = 10'd700; pixel_y = 10'd0; video_on = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    @(negedge clk);
    check("reset rgb", 32'(rgb), 32'h0);
    check("reset hsync_out", 32'(hsync_out), 32'h0);
    check("reset vsync_out", 32'(vsync_out), 32'h0);
    check("reset rd_en", 32'(bus.cell_rd_en), 32'h0);
    check("reset rd_x", 32'(bus.cell_rd_x), 32'h0);
    check("reset rd_y", 32'(bus.cell_rd_y), 32'h0);
    check("reset framenumber", 32'(framenumber), 32'h0);
    check("reset frame_tick", 32'(frame_tick), 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    idle(2);

    // Row 0 prefetch from line 79, then render line 80 area
    fetch(10'd79, 10, 5'd0);
    pix(10'd292, 10'd80, 1, 0, 0, 12'h00F);
    pix(10'd255, 10'd80, 1, 0, 0, 12'h000);
    pix(10'd254, 10'd80, 1, 0, 0, 12'h0FF);
    pix(10'd260, 10'd80, 1, 0, 0, 12'h111);
    pix(10'd250, 10'd95, 1, 0, 0, 12'h000);
    pix(10'd260, 10'd95, 1, 0, 0, 12'h111);
    pix(10'd380, 10'd81, 1, 0, 0, 12'hA0F);
    pix(10'd300, 10'd82, 1, 1, 0, 12'h00F);
    pix(10'd310, 10'd82, 1, 1, 0, 12'hF80);
    pix(10'd325, 10'd82, 1, 0, 0, 12'hFF0);
    pix(10'd345, 10'd82, 1, 0, 0, 12'h0F0);
    pix(10'd360, 10'd82, 1, 0, 0, 12'hF00);
    pix(10'd395, 10'd82, 1, 0, 0, 12'h111);
    pix(10'd238, 10'd80, 1, 0, 0, 12'h888);
    pix(10'd236, 10'd80, 1, 0, 0, 12'h888);
    pix(10'd235, 10'd80, 1, 0, 0, 12'h000);
    pix(10'd403, 10'd80, 1, 0, 0, 12'h888);
    pix(10'd404, 10'd80, 1, 0, 0, 12'h000);
    pix(10'd300, 10'd76, 1, 0, 0, 12'h888);
    pix(10'd300, 10'd75, 1, 0, 0, 12'h000);
    pix(10'd300, 10'd403, 1, 0, 0, 12'h888);
    pix(10'd300, 10'd404, 1, 0, 0, 12'h000);
    pix(10'd292, 10'd80, 0, 0, 0, 12'h000);

    // Lines whose successor is outside the cell area never fetch
    fetch(10'd78, 0, 5'd0);
    fetch(10'd399, 0, 5'd0);
    fetch(10'd524, 0, 5'd0);

    fetch(10'd191, 10, 5'd7);
    pix(10'd238, 10'd200, 1, 0, 0, 12'h888);
    pix(10'd100, 10'd200, 1, 0, 0, 12'h000);
    pix(10'd250, 10'd200, 1, 0, 0, 12'h0F0);
    pix(10'd270, 10'd200, 1, 0, 0, 12'h111);

    // Board edit during line 160 only shows after the next fetch
    fetch(10'd159, 10, 5'd5);
    pix(10'd245, 10'd160, 1, 0, 0, 12'hF00);
    board[5][0] = 3'd3;
    pix(10'd245, 10'd160, 1, 0, 0, 12'hF00);
    fetch(10'd160, 10, 5'd5);
    pix(10'd245, 10'd161, 1, 0, 0, 12'hF80);
    idle(3);

    repeat (3) vs_pulse();
    @(negedge clk);
    check("framenumber after 3 edges", 32'(framenumber), 32'd3);

    // Reset in the middle of a fetch (after col 3 issued)
    @(posedge clk); #1;
    pixel_x = 10'd640; pixel_y = 10'd199;
    for (int c = 0; c < 4; c++) rq.push_back({5'd7, 4'(c)});
    @(posedge clk); #1 pixel_x = 10'd700;
    repeat (3) @(posedge clk);
    @(negedge clk); #1 reset = 1'b1;
    exp_fn = '0;
    #1;
    check("midreset rgb", 32'(rgb), 32'h0);
    check("midreset rd_en", 32'(bus.cell_rd_en), 32'h0);
    check("midreset rd_x", 32'(bus.cell_rd_x), 32'h0);
    check("midreset rd_y", 32'(bus.cell_rd_y), 32'h0);
    check("midreset framenumber", 32'(framenumber), 32'h0);
    check("midreset frame_tick", 32'(frame_tick), 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    idle(12);
    check("midreset reads outstanding", 32'(rq.size()), 32'd0);
    pix(10'd250, 10'd200, 1, 0, 0, 12'h111);
    idle(3);

    // Frame counter wrap
    for (int i = 0; i < 1023; i++) vs_pulse();
    @(negedge clk);
    check("framenumber at 1023", 32'(framenumber), 32'd1023);
    vs_pulse();
    @(negedge clk);
    check("framenumber wrapped", 32'(framenumber), 32'd0);

    // Sync delay matches rgb
    pix(10'd100, 10'd200, 1, 0, 1, 12'h000);
    pix(10'd100, 10'd200, 1, 1, 0, 12'h000);
    idle(4);

    check("pixel queue drained", 32'(pq.size()), 32'd0);
    check("read queue drained", 32'(rq.size()), 32'd0);
    check("frame queue drained", 32'(fq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
